// File: rtl/vga_screen_pic_pipe_if.sv
// Pixel/game-state bundle into the colour pipeline and the coloured pixel out of it.
// Latency n/a; no backpressure, one pixel per clock.
interface vga_screen_pic_pipe_if #(
    parameter int N_OBS = 10
);
    logic                  pix_valid;
    logic                  frame_start;
    logic [9:0]            pix_x;
    logic [8:0]            pix_y;
    logic                  hsync_in;
    logic                  vsync_in;
    logic [1:0]            gamemode;
    logic [8:0]            player_y;
    logic [N_OBS*20-1:0]   obstacle_x;
    logic [N_OBS*18-1:0]   obstacle_y;
    logic [11:0]           rgb;
    logic                  rgb_valid;
    logic                  hsync_out;
    logic                  vsync_out;
`ifdef VGA_COLLIDE_DETECT_EN
    logic                  collide;
`endif

    modport master (
        output pix_valid, frame_start, pix_x, pix_y, hsync_in, vsync_in,
        output gamemode, player_y, obstacle_x, obstacle_y,
`ifdef VGA_COLLIDE_DETECT_EN
        input  collide,
`endif
        input  rgb, rgb_valid, hsync_out, vsync_out
    );

    modport slave (
        input  pix_valid, frame_start, pix_x, pix_y, hsync_in, vsync_in,
        input  gamemode, player_y, obstacle_x, obstacle_y,
`ifdef VGA_COLLIDE_DETECT_EN
        output collide,
`endif
        output rgb, rgb_valid, hsync_out, vsync_out
    );
endinterface

// File: rtl/vga_screen_pic_pipe.sv
// Pixel colour pipeline from per-frame shadowed game state; VGA_COLLIDE_DETECT_EN adds a collide output.
// Latency 2 clk, 1 pixel/clk, no backpressure (never stalls).
module vga_screen_pic_pipe #(
    parameter int          N_OBS        = 10,
    parameter int          PLAYER_X     = 160,
    parameter int          PLAYER_SIZE  = 40,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [11:0] C_PLAYER     = 12'h00F,
    parameter logic [11:0] C_OBS        = 12'hF70
) (
    input  logic                    clk,
    input  logic                    rst,
    vga_screen_pic_pipe_if.slave    bus
);
    localparam logic [10:0] PX_LO = 11'(PLAYER_X);
    localparam logic [10:0] PX_HI = 11'(PLAYER_X + PLAYER_SIZE);
    localparam int          CW    = $clog2(BLINK_FRAMES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);

    logic [1:0]          sh_mode;
    logic [8:0]          sh_py;
    logic [N_OBS*20-1:0] sh_ox;
    logic [N_OBS*18-1:0] sh_oy;
    logic [CW-1:0]       frame_cnt;
    logic                blink_phase;

    logic [8:0]          eff_py;
    logic [N_OBS*20-1:0] eff_ox;
    logic [N_OBS*18-1:0] eff_oy;
    logic [9:0]          py_end;
    logic                player_hit_c;
    logic                obs_hit_c;

    logic                s1_valid, s1_hs, s1_vs, s1_player, s1_obs;
    logic [11:0]         colour_c;
    logic [11:0]         rgb_q;
    logic                rgb_valid_q, hsync_q, vsync_q;

    function automatic logic slot_hit(input logic [9:0] x, input logic [8:0] y,
                                      input logic [9:0] l, input logic [9:0] r,
                                      input logic [8:0] t, input logic [8:0] b);
        return !((l == r) && (t == b)) && (x >= l) && (x < r) && (y >= t) && (y < b);
    endfunction

    // The frame_start pixel must already see the state being latched on this edge.
    assign eff_py = bus.frame_start ? bus.player_y   : sh_py;
    assign eff_ox = bus.frame_start ? bus.obstacle_x : sh_ox;
    assign eff_oy = bus.frame_start ? bus.obstacle_y : sh_oy;
    assign py_end = {1'b0, eff_py} + 10'(PLAYER_SIZE);

    always_comb begin
        player_hit_c = ({1'b0, bus.pix_x} >= PX_LO) && ({1'b0, bus.pix_x} < PX_HI) &&
                       (bus.pix_y >= eff_py) && ({1'b0, bus.pix_y} < py_end);
        obs_hit_c = 1'b0;
        for (int i = 0; i < N_OBS; i++) begin
            if (slot_hit(bus.pix_x, bus.pix_y,
                         eff_ox[i*20 +: 10], eff_ox[i*20+10 +: 10],
                         eff_oy[i*18 +: 9],  eff_oy[i*18+9 +: 9]))
                obs_hit_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_mode     <= 2'b00;
            sh_py       <= '0;
            sh_ox       <= '0;
            sh_oy       <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (bus.frame_start) begin
            sh_mode <= bus.gamemode;
            sh_py   <= bus.player_y;
            sh_ox   <= bus.obstacle_x;
            sh_oy   <= bus.obstacle_y;
            if (frame_cnt == CNT_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            s1_player <= 1'b0;
            s1_obs    <= 1'b0;
        end else begin
            s1_valid  <= bus.pix_valid;
            s1_hs     <= bus.hsync_in;
            s1_vs     <= bus.vsync_in;
            s1_player <= player_hit_c;
            s1_obs    <= obs_hit_c;
        end
    end

    // Shadow mode and blink phase already hold this frame's values when its pixels reach stage 2.
    always_comb begin
        unique case (sh_mode)
            2'b00:   colour_c = 12'hCCF;
            2'b01:   colour_c = 12'h0F0;
            2'b10:   colour_c = 12'hFF0;
            default: colour_c = blink_phase ? 12'h000 : 12'hF00;
        endcase
        if (s1_obs)
            colour_c = C_OBS;
        if (s1_player && !((sh_mode == 2'b10) && blink_phase))
            colour_c = C_PLAYER;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q       <= '0;
            rgb_valid_q <= 1'b0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
        end else begin
            rgb_q       <= s1_valid ? colour_c : 12'h000;
            rgb_valid_q <= s1_valid;
            hsync_q     <= s1_hs;
            vsync_q     <= s1_vs;
        end
    end

    assign bus.rgb       = rgb_q;
    assign bus.rgb_valid = rgb_valid_q;
    assign bus.hsync_out = hsync_q;
    assign bus.vsync_out = vsync_q;

`ifdef VGA_COLLIDE_DETECT_EN
    logic collide_flag;
    logic collide_q;
    logic hit_now;

    assign hit_now = s1_player && s1_obs && s1_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            collide_flag <= 1'b0;
            collide_q    <= 1'b0;
        end else if (bus.frame_start) begin
            collide_q    <= collide_flag;
            collide_flag <= hit_now;
        end else begin
            collide_flag <= collide_flag | hit_now;
        end
    end

    assign bus.collide = collide_q;
`endif
endmodule

// File: tb/tb_vga_screen_pic_pipe.sv
// Randomized pixel/game-state stimulus against a frame-level reference model, scoreboard-checked.
module tb_vga_screen_pic_pipe;
    localparam int N_OBS   = 10;
    localparam int BF      = 2;
    localparam int FL      = 200;
    localparam int NCYC    = 16 * FL + 20;

    typedef struct {
        int          tgt;
        logic [14:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pe = 0;
    int   passed = 0;
    int   total = 0;
    exp_t q[$];

    int                  cur_mode, cur_py;
    logic [N_OBS*20-1:0] cur_ox;
    logic [N_OBS*18-1:0] cur_oy;
    int                  m_mode, m_py, m_frames;
    logic [N_OBS*20-1:0] m_ox;
    logic [N_OBS*18-1:0] m_oy;

    vga_screen_pic_pipe_if #(.N_OBS(N_OBS)) vif();

    vga_screen_pic_pipe #(.N_OBS(N_OBS), .BLINK_FRAMES(BF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) pe <= pe + 1;

    function automatic bit rst_at(input int k);
        return (k < 4) || (k >= 1700 && k < 1703);
    endfunction

    function automatic logic [11:0] ref_colour(input int x, input int y, input int mode,
                                               input int py, input logic [N_OBS*20-1:0] ox,
                                               input logic [N_OBS*18-1:0] oy, input int phase);
        bit ph, oh;
        int l, r, t, b;
        logic [11:0] c;
        ph = (x >= 160) && (x < 200) && (y >= py) && (y < py + 40);
        oh = 0;
        for (int i = 0; i < N_OBS; i++) begin
            l = int'(ox[i*20 +: 10]);
            r = int'(ox[i*20+10 +: 10]);
            t = int'(oy[i*18 +: 9]);
            b = int'(oy[i*18+9 +: 9]);
            if (!(l == r && t == b) && x >= l && x < r && y >= t && y < b) oh = 1;
        end
        case (mode)
            0:       c = 12'hCCF;
            1:       c = 12'h0F0;
            2:       c = 12'hFF0;
            default: c = (phase == 1) ? 12'h000 : 12'hF00;
        endcase
        if (oh) c = 12'hF70;
        if (ph && !(mode == 2 && phase == 1)) c = 12'h00F;
        return c;
    endfunction

    task automatic rand_state();
        int l, t;
        cur_mode = $urandom_range(0, 3);
        cur_py   = ($urandom_range(0, 7) == 0) ? $urandom_range(440, 511) : $urandom_range(0, 300);
        for (int i = 0; i < N_OBS; i++) begin
            l = $urandom_range(80, 260);
            t = $urandom_range(0, 300);
            case ($urandom_range(0, 3))
                0: begin
                    cur_ox[i*20 +: 20] = {10'(l), 10'(l)};
                    cur_oy[i*18 +: 18] = {9'(t), 9'(t)};
                end
                1: begin
                    cur_ox[i*20 +: 20] = {10'(l), 10'(l + 30)};
                    cur_oy[i*18 +: 18] = {9'(t + 20), 9'(t + 40)};
                end
                default: begin
                    cur_ox[i*20 +: 20] = {10'(l + $urandom_range(1, 60)), 10'(l)};
                    cur_oy[i*18 +: 18] = {9'(t + $urandom_range(1, 60)), 9'(t)};
                end
            endcase
        end
    endtask

    initial begin : driver
        int          x, y;
        logic        v, hs, vs, fs;
        logic [14:0] e;
        exp_t        ent;
        vif.pix_valid = 0; vif.frame_start = 0; vif.pix_x = 0; vif.pix_y = 0;
        vif.hsync_in = 0; vif.vsync_in = 0; vif.gamemode = 0; vif.player_y = 0;
        vif.obstacle_x = '0; vif.obstacle_y = '0;
        m_mode = 0; m_py = 0; m_ox = '0; m_oy = '0; m_frames = 0;
        rand_state();
        for (int k = 0; k < NCYC; k++) begin
            @(posedge clk); #1;
            rst = rst_at(k);
            if ($urandom_range(0, 39) == 0) rand_state();
            fs = (k % FL == 10);
            if (fs) begin
                x = 0; y = 0; v = 1;
            end else begin
                v = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 3) == 0) begin
                    x = $urandom_range(0, 1023);
                    y = $urandom_range(0, 511);
                end else begin
                    x = $urandom_range(60, 300);
                    y = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 511)
                                                    : m_py - 5 + $urandom_range(0, 50);
                    if (y < 0) y = 0;
                    if (y > 511) y = 511;
                end
            end
            hs = 1'($urandom_range(0, 1));
            vs = 1'($urandom_range(0, 1));
            vif.frame_start = fs; vif.pix_valid = v;
            vif.pix_x = 10'(x); vif.pix_y = 9'(y);
            vif.hsync_in = hs; vif.vsync_in = vs;
            vif.gamemode = 2'(cur_mode); vif.player_y = 9'(cur_py);
            vif.obstacle_x = cur_ox; vif.obstacle_y = cur_oy;

            if (rst_at(k)) begin
                m_mode = 0; m_py = 0; m_ox = '0; m_oy = '0; m_frames = 0;
            end else if (fs) begin
                m_mode = cur_mode; m_py = cur_py; m_ox = cur_ox; m_oy = cur_oy;
                m_frames++;
            end
            if (rst_at(k) || rst_at(k + 1))
                e = '0;
            else
                e = {v ? ref_colour(x, y, m_mode, m_py, m_ox, m_oy, (m_frames / BF) % 2) : 12'h000,
                     v, hs, vs};
            ent.tgt = pe + 2;
            ent.exp = e;
            q.push_back(ent);
        end
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        total++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain: %0d entries left, required 0", q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin : monitor
        exp_t        ent;
        logic [14:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].tgt <= pe) begin
                ent = q.pop_front();
                act = {vif.rgb, vif.rgb_valid, vif.hsync_out, vif.vsync_out};
                total++;
                if (ent.tgt != pe)
                    $display("FAIL pix_late: due edge %0d seen at %0d", ent.tgt, pe);
                else if (act !== ent.exp)
                    $display("FAIL pix @%0d: got rgb=%h v=%b hs=%b vs=%b, required rgb=%h v=%b hs=%b vs=%b",
                             pe, act[14:3], act[2], act[1], act[0],
                             ent.exp[14:3], ent.exp[2], ent.exp[1], ent.exp[0]);
                else
                    passed++;
            end
        end
    end

    initial begin : watchdog
        #(20 * (NCYC + 100));
        $display("FAIL timeout: run did not finish, %0d checks done", total);
        $fatal(1);
    end
endmodule

// File: doc/vga_screen_pic_pipe.md
Name: vga_screen_pic_pipe

Overview:
Pipelined, parametrised pixel colour generator for the game display. It takes the pixel scan position from the VGA timing block and the game state from game_logic, and produces a registered 12-bit colour with sync signals delayed to match. Game state is captured once per frame so the picture never tears mid-frame. The player sprite blinks while paused, and the background flashes on game over.

Parameters:
N_OBS, 10, number of obstacle slots (1..16)
PLAYER_X, 160, player left edge in pixels
PLAYER_SIZE, 40, player square side in pixels
BLINK_FRAMES, 30, frames per blink half-period (≥1)
C_PLAYER, 12'h00F, player colour
C_OBS, 12'hF70, obstacle colour

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous, active-high reset
pix_valid  in  1  current pixel is in the active area
frame_start  in  1  one-cycle pulse coincident with pixel (0,0) of each frame
pix_x  in  10  pixel X
pix_y  in  9  pixel Y
hsync_in  in  1  horizontal sync from timing block
vsync_in  in  1  vertical sync from timing block
gamemode  in  2  00 init, 01 run, 10 pause, 11 end
player_y  in  9  player top Y
obstacle_x  in  N_OBS*20  per slot i: [i*20+:10] left edge, [i*20+10+:10] right edge
obstacle_y  in  N_OBS*18  per slot i: [i*18+:9] top edge, [i*18+9+:9] bottom edge
rgb  out  12  R[11:8] G[7:4] B[3:0]
rgb_valid  out  1  pix_valid delayed by 2 cycles
hsync_out  out  1  hsync_in delayed by 2 cycles
vsync_out  out  1  vsync_in delayed by 2 cycles

Behaviour:
- Reset (sync, active-high) clears the following to 0: rgb, rgb_valid, hsync_out, vsync_out, all pipeline registers, shadow registers, frame counter, blink_phase.
- Shadow registers: when frame_start=1, gamemode, player_y, obstacle_x and obstacle_y are latched. All colour decisions use only the shadow values, and the pixel carrying frame_start already uses the newly latched values (bypass on that cycle). After reset, the shadows read as gamemode=00 with all-zero geometry until the first frame_start.
- Frame counter: increments on each frame_start. When it reaches BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- Stage 1 (registered):
  - Player hit: PLAYER_X ≤ x < PLAYER_X+PLAYER_SIZE and py ≤ y < py+PLAYER_SIZE.
  - py+PLAYER_SIZE is computed at 10 bits, so it does not wrap.
  - obs_hit is the OR over slots of (L ≤ x < R) and (T ≤ y < B).
  - A slot with L==R and T==B is empty and never hits. A slot with L>R or T>B naturally produces no hits.
  - pix_valid, hsync and vsync are delayed one stage alongside.
- Stage 2 (registered):
  - Background by mode: 00 → 12'hCCF, 01 → 12'h0F0, 10 → 12'hFF0, 11 → 12'hF00, or 12'h000 when blink_phase=1.
  - If obs_hit, colour is C_OBS.
  - If player_hit and not (mode 10 and blink_phase=1), colour is C_PLAYER.
  - Priority: player > obstacle > background.
  - If the delayed pix_valid=0, rgb=0.
- Latency: exactly 2 clk cycles from input to rgb/rgb_valid/syncs, at a throughput of 1 pixel per clock with no stalls.
- frame_start asserted during reset is ignored. Reset mid-frame forces the outputs to 0 on the next edge, and the pipeline refills 2 cycles after rst deasserts.
- Game state changes mid-frame have no visible effect until the next frame_start.

Optional Feature:
Macro: VGA_COLLIDE_DETECT_EN
- With the macro defined:
  - Extra output collide (1 bit, reset 0).
  - A sticky internal flag sets in stage 2 when player_hit && obs_hit && delayed pix_valid.
  - On each frame_start, collide is loaded with the flag and the flag is cleared. If a hit occurs on that same cycle, it counts toward the new frame.
  - collide is therefore constant for a whole frame and reports the previous frame.
- Without the macro: the port, the flag and the logic are absent.

Test Plan:
- Reset, then 1 frame with mode 01 and all obstacle slots zero: pixel (0,0) produces rgb=12'h0F0 two cycles later, and rgb=0 whenever pix_valid=0.
- player_y=100, mode 01: rgb=12'h00F for (160,100) and (199,139); rgb=12'h0F0 for (200,100) and (160,140).
- Slot 3 = L100 R150 T50 B80: (100,50) gives 12'hF70 and (150,50) gives 12'h0F0. Moving it to L150 R200 overlapping the player at y=60 with player_y=40: (170,60) gives 12'h00F.
- Mode 10, BLINK_FRAMES=2: the player pixel alternates between 12'h00F and 12'hFF0 every 2 frames. Mode 11: the background alternates between 12'hF00 and 12'h000 every 2 frames.
- Change player_y from 100 to 200 mid-frame: the rest of the frame still draws at 100, and from the next frame_start onward it draws at 200. hsync_out and vsync_out equal the inputs delayed 2 cycles throughout.
- (VGA_COLLIDE_DETECT_EN) Obstacle overlapping the player during frame k: collide=1 from frame k+1's frame_start through frame k+1; obstacle cleared → collide=0 in frame k+2.
